// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - prescaled up/down step counter with busy/done handshake; optional pause port under TICK_SEQ_PAUSE_EN
module tick_sequencer #(
   parameter int CLK_FREQ = 30000000,
   parameter int TICK_HZ  = 2,
   parameter int WIDTH    = 4
) (
   input  logic             clk30,
   input  logic             rst_n,
   input  logic             go,
   input  logic             stop,
   input  logic             dir,
   input  logic             repeat_en,
`ifdef TICK_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             done_flag
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
   localparam logic [PW-1:0]    PRE_ONE = PW'(1);
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   // A step rate faster than half the clock cannot be produced by the prescaler
   if (DIV < 2) begin : g_div_check
      $error("tick_sequencer: CLK_FREQ/TICK_HZ must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             dir_q, dir_d;
   logic             rep_q, rep_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             flag_q, flag_d;
   logic             pause_w;
   logic             tick;
   logic             accept;
   logic [WIDTH-1:0] terminal;

`ifdef TICK_SEQ_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   // State and output registers; reset clears everything at once, even mid-run
   always_ff @(posedge clk30 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         limit_q <= '0;
         pre_q   <= '0;
         dir_q   <= 1'b0;
         rep_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         pre_q   <= pre_d;
         dir_q   <= dir_d;
         rep_q   <= rep_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         flag_q  <= flag_d;
      end
   end

   // Next state: stop beats go beats tick; the prescaler only runs in RUN
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      limit_d  = limit_q;
      dir_d    = dir_q;
      rep_d    = rep_q;
      pre_d    = '0;
      done_d   = 1'b0;
      accept   = 1'b0;
      tick     = (pre_q == PRE_MAX);
      terminal = dir_q ? '0 : limit_q;

      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            accept  = go && !stop;
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (pause_w) begin
               pre_d = pre_q;
            end else if (tick) begin
               if (count_q == terminal) begin
                  done_d = 1'b1;
                  if (rep_q) begin
                     count_d = dir_q ? limit_q : '0;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  count_d = dir_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
               end
            end else begin
               pre_d = pre_q + PRE_ONE;
            end
         end
         ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               accept = go;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase

      // Accepting go latches the run configuration and loads the start value
      if (accept) begin
         state_d = ST_RUN;
         limit_d = limit;
         dir_d   = dir;
         rep_d   = repeat_en;
         count_d = dir ? limit : '0;
         pre_d   = '0;
      end

      busy_d = (state_d == ST_RUN);
      flag_d = (state_d == ST_DONE);
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_flag = flag_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - scoreboard bench for tick_sequencer against a step-count reference model
module tb_tick_sequencer;

   localparam int DIV = 4;
`ifdef TICK_SEQ_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   logic       clk30 = 1'b0;
   logic       rst_n = 1'b0;
   logic       go = 1'b0;
   logic       stop = 1'b0;
   logic       dir = 1'b0;
   logic       repeat_en = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] limit = 4'd0;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       done_flag;

   int n_tests = 0;
   int n_fail  = 0;
   bit rst_req = 1'b1;

   typedef struct packed {
      logic [3:0] cnt;
      logic       busy;
      logic       done;
      logic       flag;
   } snap_t;

   snap_t sb_q[$];
   snap_t mon_exp;
   snap_t mon_act;

   // reference model: 0 idle, 1 run, 2 done; count derived from elapsed run cycles
   int m_mode = 0;
   int m_lim  = 0;
   bit m_dir  = 1'b0;
   bit m_rep  = 1'b0;
   int m_el   = 0;
   int m_cnt  = 0;
   bit m_done = 1'b0;

   tick_sequencer #(
      .CLK_FREQ(8),
      .TICK_HZ (2),
      .WIDTH   (4)
   ) dut (
      .clk30    (clk30),
      .rst_n    (rst_n),
      .go       (go),
      .stop     (stop),
      .dir      (dir),
      .repeat_en(repeat_en),
`ifdef TICK_SEQ_PAUSE_EN
      .pause    (pause),
`endif
      .limit    (limit),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .done_flag(done_flag)
   );

   always #5 clk30 = ~clk30;

   task automatic model_edge();
      m_done = 1'b0;
      if (!rst_n) begin
         m_mode = 0;
         m_cnt  = 0;
      end else if (m_mode != 0 && stop) begin
         m_mode = 0;
         m_cnt  = 0;
      end else if ((m_mode == 0 || m_mode == 2) && go && !stop) begin
         m_mode = 1;
         m_lim  = int'(limit);
         m_dir  = dir;
         m_rep  = repeat_en;
         m_el   = 0;
         m_cnt  = dir ? int'(limit) : 0;
      end else if (m_mode == 1 && !pause) begin
         m_el++;
         if (m_el % DIV == 0) begin
            int steps;
            int k;
            steps = m_el / DIV;
            k     = steps % (m_lim + 1);
            if (k == 0) begin
               m_done = 1'b1;
               if (!m_rep) begin
                  m_mode = 2;
                  m_cnt  = m_dir ? 0 : m_lim;
               end else begin
                  m_cnt = m_dir ? m_lim : 0;
               end
            end else begin
               m_cnt = m_dir ? (m_lim - k) : k;
            end
         end
      end
   endtask

   task automatic cyc(input bit g, input bit s, input bit p, input int lim, input bit d, input bit r);
      snap_t e;
      @(negedge clk30);
      rst_n     = !rst_req;
      go        = g;
      stop      = s;
      pause     = PAUSE_EN & p;
      limit     = lim[3:0];
      dir       = d;
      repeat_en = r;
      model_edge();
      e.cnt  = m_cnt[3:0];
      e.busy = (m_mode == 1);
      e.done = m_done;
      e.flag = (m_mode == 2);
      sb_q.push_back(e);
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk30);
      #2;
   endtask

   // monitor: every clock edge that has a queued expectation is compared
   always @(posedge clk30) begin
      #1;
      if (sb_q.size() != 0) begin
         mon_exp = sb_q.pop_front();
         mon_act = {count, busy, done, done_flag};
         n_tests++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t: count=%0d busy=%b done=%b done_flag=%b, expected count=%0d busy=%b done=%b done_flag=%b",
                     $time, mon_act.cnt, mon_act.busy, mon_act.done, mon_act.flag,
                     mon_exp.cnt, mon_exp.busy, mon_exp.done, mon_exp.flag);
         end
      end
   end

   initial begin
      // reset state
      rst_req = 1'b1;
      run_idle(3);
      after_edge();
      chk("reset_count", 32'(count), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_flag", 32'(done_flag), 0);
      rst_req = 1'b0;
      run_idle(2);

      // up one-shot, limit 3: done after e16
      cyc(1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
      run_idle(16);
      after_edge();
      chk("up_done", 32'(done), 1);
      chk("up_flag", 32'(done_flag), 1);
      chk("up_busy", 32'(busy), 0);
      chk("up_count", 32'(count), 3);

      // restart from DONE with limit 1: done at +8
      cyc(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      run_idle(8);
      after_edge();
      chk("restart_done", 32'(done), 1);
      chk("restart_count", 32'(count), 1);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // down repeat, limit 2: second done at e24, still busy
      cyc(1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      run_idle(24);
      after_edge();
      chk("rep_done", 32'(done), 1);
      chk("rep_busy", 32'(busy), 1);
      chk("rep_count", 32'(count), 2);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // stop at e6 mid-run
      cyc(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0);
      run_idle(5);
      cyc(1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
      after_edge();
      chk("stop_count", 32'(count), 0);
      chk("stop_busy", 32'(busy), 0);
      chk("stop_done", 32'(done), 0);

      // asynchronous reset mid-run, observed before any clock edge
      cyc(1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b0);
      run_idle(6);
      @(posedge clk30);
      #3;
      rst_req = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_busy", 32'(busy), 0);
      run_idle(2);
      rst_req = 1'b0;
      run_idle(1);

      // limit 0 up: terminal on the first tick
      cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run_idle(4);
      after_edge();
      chk("lim0_done", 32'(done), 1);
      chk("lim0_flag", 32'(done_flag), 1);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // go and stop together in IDLE
      for (int i = 0; i < 6; i++)
         cyc(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0);
      after_edge();
      chk("gostop_busy", 32'(busy), 0);
      chk("gostop_count", 32'(count), 0);

`ifdef TICK_SEQ_PAUSE_EN
      // pause over e6..e13 freezes the prescaler after the first step
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++)
         cyc(1'b0, 1'b0, (i >= 6 && i <= 13), 0, 1'b0, 1'b0);
      after_edge();
      chk("pause_count", 32'(count), 2);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
`endif

      // randomized traffic
      for (int i = 0; i < 1500; i++)
         cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
             1'($urandom), 1'($urandom));

      @(posedge clk30);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
